// File: rtl/jk_seq_pkg.sv
// Shared definitions for the JK-flip-flop based sequence controller.
// The state encoding is also imported by the testbench reference model.
package jk_seq_pkg;

    // Controller states; the encodings are fixed so external tools can decode them
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_t;

    // Default counter width (also the number of flip-flops in the bank)
    localparam int DEFAULT_WIDTH = 4;

    // Per-bit JK excitation: set when going 0->1, reset when going 1->0
    function automatic logic [1:0] jk_excite(input logic q, input logic nxt);
        return {~q & nxt, q & ~nxt};
    endfunction

endpackage : jk_seq_pkg

// File: rtl/jk_seq_ctrl_jk_ff.sv
// Single JK flip-flop: hold / reset / set / toggle on the rising clock edge.
// It has no reset of its own; the controller clears it by driving j=0, k=1.
module jk_ff (
    input  logic clk,
    input  logic j,
    input  logic k,
    output logic q
);

    // Classic JK behaviour
    always_ff @(posedge clk) begin
        case ({j, k})
            2'b00:   q <= q;
            2'b01:   q <= 1'b0;
            2'b10:   q <= 1'b1;
            default: q <= ~q;
        endcase
    end

endmodule : jk_ff

// File: rtl/jk_seq_ctrl.sv
// Modulo up/down sequence counter built from a bank of JK flip-flops.
// The controller computes the required next count and only ever reaches
// the count through the j/k excitation of each flip-flop.
module jk_seq_ctrl
    import jk_seq_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             up,
    input  logic [WIDTH-1:0] mod_n,
    input  logic             one_shot,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             wrap,
    output logic             done
);

    state_t           r_state;
    state_t           w_state_next;
    logic             r_wrap;
    logic             r_done;
    logic             w_wrap_next;
    logic             w_done_next;
    logic [WIDTH-1:0] w_count;
    logic [WIDTH-1:0] w_nxt;
    logic [WIDTH-1:0] w_j;
    logic [WIDTH-1:0] w_k;

    // One extra bit so that a modulus of 2^WIDTH (mod_n == 0) is representable
    logic [WIDTH:0]   w_mod;
    logic [WIDTH:0]   w_mod_m1;
    logic [WIDTH:0]   w_count_ext;
    logic [WIDTH:0]   w_load_ext;

    assign w_mod       = (mod_n == '0) ? {1'b1, {WIDTH{1'b0}}} : {1'b0, mod_n};
    assign w_mod_m1    = w_mod - (WIDTH+1)'(1);
    assign w_count_ext = {1'b0, w_count};
    assign w_load_ext  = {1'b0, load_val};

    // State and pulse registers; synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_wrap  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_wrap  <= w_wrap_next;
            r_done  <= w_done_next;
        end
    end

    // Next-state, next-count and pulse decode; load overrides everything else
    always_comb begin
        w_state_next = r_state;
        w_nxt        = w_count;
        w_wrap_next  = 1'b0;
        w_done_next  = 1'b0;

        if (load) begin
            // Out-of-range load values fold to zero; state and pulses untouched
            w_nxt = (w_load_ext >= w_mod) ? '0 : load_val;
        end else begin
            case (r_state)
                ST_IDLE, ST_PAUSE: begin
                    // stop beats start, so both high simply holds here
                    if (start && !stop) begin
                        w_state_next = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (stop) begin
                        // The stopping edge must not advance the count
                        w_state_next = ST_PAUSE;
                    end else begin
                        if (w_count_ext >= w_mod) begin
                            // Modulus lowered below the current count: restart at 0
                            w_nxt       = '0;
                            w_wrap_next = 1'b1;
                        end else if (up) begin
                            if (w_count_ext == w_mod_m1) begin
                                w_nxt       = '0;
                                w_wrap_next = 1'b1;
                            end else begin
                                w_nxt = w_count + WIDTH'(1);
                            end
                        end else begin
                            if (w_count == '0) begin
                                w_nxt       = w_mod_m1[WIDTH-1:0];
                                w_wrap_next = 1'b1;
                            end else begin
                                w_nxt = w_count - WIDTH'(1);
                            end
                        end

                        // A one-shot run ends on the very edge that wraps
                        if (w_wrap_next && one_shot) begin
                            w_state_next = ST_IDLE;
                            w_done_next  = 1'b1;
                        end
                    end
                end
                default: begin
                    w_state_next = ST_IDLE;
                end
            endcase
        end
    end

    // Flip-flop bank with its excitation; during reset every bit is cleared
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bank
        logic [1:0] w_jk;

        assign w_jk     = jk_excite(w_count[gi], w_nxt[gi]);
        assign w_j[gi]  = rst_n ? w_jk[1] : 1'b0;
        assign w_k[gi]  = rst_n ? w_jk[0] : 1'b1;

        jk_ff u_jk_ff (
            .clk (clk),
            .j   (w_j[gi]),
            .k   (w_k[gi]),
            .q   (w_count[gi])
        );
    end

    assign count = w_count;
    assign busy  = (r_state == ST_RUN);
    assign wrap  = r_wrap;
    assign done  = r_done;

endmodule : jk_seq_ctrl
